// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard unit for the five-stage MIPS core. It keeps a shadow copy
// of the destination registers in EX and MEM and a HI/LO busy counter. From
// these it produces the combinational ID stall and the registered EX
// operand-forwarding selects.
//
// Register numbers: 0 = none, 1..31 = GPR, 33 = HI/LO pair (never tracked
// in the shadow pipe, only through the busy counter).
//
// Configuration macro: HAZARD_FORWARD_EN
//   defined   : EX/MEM and MEM/WB forwarding selects are generated; only
//               load-use and HI/LO-busy hazards stall.
//   undefined : selects are tied to 2'b00; any GPR source that matches an
//               in-flight producer stalls until that producer reaches WB.
//
// Parameters:
//   MULDIV_LAT      cycles from MULTU/DIVU entering EX until HI/LO is written (>=1)
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   id_valid_i      ID holds a real instruction
//   id_read1_i      first source register number
//   id_read2_i      second source register number
//   id_write_i      destination register number
//   id_is_load_i    ID instruction is a load
//   id_is_muldiv_i  ID instruction is MULTU/DIVU
//   flush_i         ID instruction is squashed (taken branch/jump)
//   hold_i          global freeze (memory wait)
//   stall_o         freeze PC and IF/ID, inject a bubble into EX
//   ex_fwd_a_o      EX operand A select: 00 regfile, 01 MEM, 10 WB
//   ex_fwd_b_o      EX operand B select
//   muldiv_busy_o   HI/LO counter is nonzero
// ----------------------------------------------------------------------------
module hazard_unit #(
    parameter int MULDIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid_i,
    input  logic [5:0] id_read1_i,
    input  logic [5:0] id_read2_i,
    input  logic [5:0] id_write_i,
    input  logic       id_is_load_i,
    input  logic       id_is_muldiv_i,
    input  logic       flush_i,
    input  logic       hold_i,
    output logic       stall_o,
    output logic [1:0] ex_fwd_a_o,
    output logic [1:0] ex_fwd_b_o,
    output logic       muldiv_busy_o
);

    localparam int         CNT_W    = $clog2(MULDIV_LAT + 1);
    localparam logic [5:0] REG_NONE = 6'd0;
    localparam logic [5:0] REG_HILO = 6'd33;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // A source only matches a real, tracked GPR.
    function automatic logic src_match(input logic [5:0] src, input logic [5:0] entry);
        return (src == entry) && (src != REG_NONE) && (src != REG_HILO);
    endfunction

    logic [5:0]       ex_wr_q,  ex_wr_d;
    logic             ex_ld_q,  ex_ld_d;
    logic [5:0]       mem_wr_q, mem_wr_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    fwd_sel_e         fwd_a_q,  fwd_a_d;
    fwd_sel_e         fwd_b_q,  fwd_b_d;

    logic a_ex, b_ex, a_mem, b_mem;
    logic load_use, hilo_busy, raw_wait;
    logic advance, issue;
    fwd_sel_e sel_a, sel_b;

    assign a_ex  = src_match(id_read1_i, ex_wr_q);
    assign b_ex  = src_match(id_read2_i, ex_wr_q);
    assign a_mem = src_match(id_read1_i, mem_wr_q);
    assign b_mem = src_match(id_read2_i, mem_wr_q);

    assign load_use  = id_valid_i && ex_ld_q && (a_ex || b_ex);
    assign hilo_busy = id_valid_i && (md_cnt_q != '0) &&
                       ((id_read1_i == REG_HILO) || (id_read2_i == REG_HILO) || id_is_muldiv_i);

`ifdef HAZARD_FORWARD_EN
    assign raw_wait = 1'b0;
    // The newer producer (EX) wins over the older one (MEM).
    assign sel_a = a_ex ? FWD_MEM : (a_mem ? FWD_WB : FWD_RF);
    assign sel_b = b_ex ? FWD_MEM : (b_mem ? FWD_WB : FWD_RF);
`else
    // Without forwarding every in-flight GPR producer must drain to WB first;
    // this also covers load-use.
    assign raw_wait = id_valid_i && (a_ex || b_ex || a_mem || b_mem);
    assign sel_a    = FWD_RF;
    assign sel_b    = FWD_RF;
`endif

    assign stall_o = load_use || hilo_busy || raw_wait;

    assign advance = !hold_i;
    // flush wins over stall: a squashed instruction never issues.
    assign issue   = advance && id_valid_i && !stall_o && !flush_i;

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        ex_wr_d  = ex_wr_q;
        ex_ld_d  = ex_ld_q;
        mem_wr_d = mem_wr_q;
        fwd_a_d  = fwd_a_q;
        fwd_b_d  = fwd_b_q;
        md_cnt_d = md_cnt_q;

        if (advance) begin
            mem_wr_d = ex_wr_q;
            if (issue) begin
                // HI/LO results are tracked by the counter, not the shadow pipe.
                ex_wr_d = (id_is_muldiv_i || id_write_i == REG_HILO) ? REG_NONE : id_write_i;
                ex_ld_d = id_is_load_i;
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end else begin
                ex_wr_d = REG_NONE;
                ex_ld_d = 1'b0;
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end
        end

        // The counter runs independently of hold so a freeze never extends it.
        if (issue && id_is_muldiv_i) begin
            md_cnt_d = CNT_W'(MULDIV_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wr_q  <= REG_NONE;
            ex_ld_q  <= 1'b0;
            mem_wr_q <= REG_NONE;
            md_cnt_q <= '0;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
        end else begin
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            mem_wr_q <= mem_wr_d;
            md_cnt_q <= md_cnt_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign ex_fwd_a_o    = fwd_a_q;
    assign ex_fwd_b_o    = fwd_b_q;
    assign muldiv_busy_o = (md_cnt_q != '0);

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed hazard sequences followed by random instruction streams, all
// checked against a transaction-level model: an in-flight list of
// {destination, load flag, forward selects} per stage and an absolute
// "HI/LO ready" cycle number in place of the hardware countdown.
// Honors HAZARD_FORWARD_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int LAT = 4;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [5:0] id_read1, id_read2, id_write;
    logic       id_is_load, id_is_muldiv, flush, hold;
    logic       stall;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       muldiv_busy;

    hazard_unit #(.MULDIV_LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid),
        .id_read1_i     (id_read1),
        .id_read2_i     (id_read2),
        .id_write_i     (id_write),
        .id_is_load_i   (id_is_load),
        .id_is_muldiv_i (id_is_muldiv),
        .flush_i        (flush),
        .hold_i         (hold),
        .stall_o        (stall),
        .ex_fwd_a_o     (ex_fwd_a),
        .ex_fwd_b_o     (ex_fwd_b),
        .muldiv_busy_o  (muldiv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0] dest;   // 0 when nothing trackable is in flight
        logic       ld;
        logic [1:0] sa, sb; // selects this instruction carries in EX
    } slot_t;

    slot_t pipe[2];        // [0] = EX, [1] = MEM
    int    cyc;            // rising edges seen since time zero
    int    hilo_ready;     // first cycle at which HI/LO is no longer busy

    function automatic logic gpr_hit(input logic [5:0] src, input logic [5:0] dest);
        return (src != 0) && (src != 33) && (src == dest);
    endfunction

    function automatic logic [1:0] fwd_of(input logic [5:0] src);
        if (!FWD)                   return 2'b00;
        if (gpr_hit(src, pipe[0].dest)) return 2'b01;
        if (gpr_hit(src, pipe[1].dest)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic model_stall(input logic v, input logic [5:0] r1, input logic [5:0] r2,
                                         input logic md);
        logic lu, hl, raw;
        lu  = pipe[0].ld && (gpr_hit(r1, pipe[0].dest) || gpr_hit(r2, pipe[0].dest));
        hl  = (cyc < hilo_ready) && (r1 == 33 || r2 == 33 || md);
        raw = !FWD && (gpr_hit(r1, pipe[0].dest) || gpr_hit(r2, pipe[0].dest) ||
                       gpr_hit(r1, pipe[1].dest) || gpr_hit(r2, pipe[1].dest));
        return v && (lu || hl || raw);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) pipe[i] = '{dest: 6'd0, ld: 1'b0, sa: 2'b00, sb: 2'b00};
        hilo_ready = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive ID at the falling edge, check, then advance the model
    // at the rising edge. Returns the expected stall.
    task automatic step(input logic v, input logic [5:0] r1, input logic [5:0] r2,
                        input logic [5:0] w, input logic ld, input logic md,
                        input logic fl, input logic hd, output logic st);
        slot_t nw;
        logic  iss;
        id_valid = v; id_read1 = r1; id_read2 = r2; id_write = w;
        id_is_load = ld; id_is_muldiv = md; flush = fl; hold = hd;
        #1;
        st = model_stall(v, r1, r2, md);
        check("stall",       stall,       st);
        check("ex_fwd_a",    ex_fwd_a,    pipe[0].sa);
        check("ex_fwd_b",    ex_fwd_b,    pipe[0].sb);
        check("muldiv_busy", muldiv_busy, cyc < hilo_ready);
        @(posedge clk);
        if (!hd) begin
            iss = v && !st && !fl;
            if (iss) begin
                nw.dest = (md || w == 33) ? 6'd0 : w;
                nw.ld   = ld;
                nw.sa   = fwd_of(r1);
                nw.sb   = fwd_of(r2);
                if (md) hilo_ready = cyc + 1 + LAT;
            end else begin
                nw = '{dest: 6'd0, ld: 1'b0, sa: 2'b00, sb: 2'b00};
            end
            pipe[1] = pipe[0];
            pipe[0] = nw;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Keep presenting one instruction until it issues; count stall cycles.
    task automatic issue_counting(input string tag, input logic [5:0] r1, input logic [5:0] r2,
                                  input logic [5:0] w, input logic ld, input logic md,
                                  output int n);
        logic st;
        n = 0;
        do begin
            step(1'b1, r1, r2, w, ld, md, 1'b0, 1'b0, st);
            if (st) n++;
        end while (st && n < 20);
        if (n >= 20) check({tag, "_issue_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic nop();
        logic st;
        step(1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic st;
        int   n;
        logic [5:0] pool [6];
        pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd31, 6'd33};

        cyc = 0;
        model_reset();
        rst = 1'b1;
        id_valid = 1'b0; id_read1 = '0; id_read2 = '0; id_write = '0;
        id_is_load = 1'b0; id_is_muldiv = 1'b0; flush = 1'b0; hold = 1'b0;
        @(negedge clk);
        #1;
        check("rst_stall", stall,       1'b0);
        check("rst_fwd_a", ex_fwd_a,    2'b00);
        check("rst_fwd_b", ex_fwd_b,    2'b00);
        check("rst_busy",  muldiv_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ADDU $3 ; ADDU $4,$3,$3
        step(1'b1, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, st);
        issue_counting("addu_pair", 6'd3, 6'd3, 6'd4, 1'b0, 1'b0, n);
        check("addu_pair_stalls", 32'(n), FWD ? 32'd0 : 32'd2);
        nop(); nop(); nop();

        // ADDU $3 ; NOP ; OR $5,$3,$0
        step(1'b1, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, st);
        nop();
        issue_counting("or_wb", 6'd3, 6'd0, 6'd5, 1'b0, 1'b0, n);
        check("or_wb_stalls", 32'(n), FWD ? 32'd0 : 32'd1);
        nop(); nop(); nop();

        // LW $8 ; SUBU $9,$8,$1
        step(1'b1, 6'd2, 6'd0, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, st);
        issue_counting("load_use", 6'd8, 6'd1, 6'd9, 1'b0, 1'b0, n);
        check("load_use_stalls", 32'(n), FWD ? 32'd1 : 32'd2);
        nop(); nop(); nop();

        // MULTU ; MFLO, with a hold in the middle of the count
        step(1'b1, 6'd4, 6'd5, 6'd33, 1'b0, 1'b1, 1'b0, 1'b0, st);
        step(1'b1, 6'd33, 6'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0, st);
        step(1'b1, 6'd33, 6'd0, 6'd6, 1'b0, 1'b0, 1'b0, 1'b1, st);
        issue_counting("mflo", 6'd33, 6'd0, 6'd6, 1'b0, 1'b0, n);
        check("mflo_stalls", 32'(n + 2), 32'(LAT));
        nop(); nop(); nop();

        // ADDU $0 ; ADDU $2,$0,$0
        step(1'b1, 6'd1, 6'd2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, st);
        issue_counting("zero_reg", 6'd0, 6'd0, 6'd2, 1'b0, 1'b0, n);
        check("zero_reg_stalls", 32'(n), 32'd0);
        nop(); nop(); nop();

        // ADDU $3 ; flushed ADDU $4,$3,$3 -> bubble in EX
        step(1'b1, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, st);
        step(1'b1, 6'd3, 6'd3, 6'd4, 1'b0, 1'b0, 1'b1, 1'b0, st);
        nop(); nop(); nop();

        // Reset asserted while a consumer is stalled behind a load.
        step(1'b1, 6'd2, 6'd0, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, st);
        step(1'b1, 6'd8, 6'd1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, st);
        check("pre_reset_stalled", 32'(st), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", stall,       1'b0);
        check("mid_rst_fwd_a", ex_fwd_a,    2'b00);
        check("mid_rst_busy",  muldiv_busy, 1'b0);
        model_reset();
        @(posedge clk); cyc++;
        @(negedge clk);
        rst = 1'b0;

        // Random instruction streams.
        for (int i = 0; i < 600; i++) begin
            logic       v, ld, md, fl, hd;
            logic [5:0] r1, r2, w;
            v  = ($urandom_range(0, 99) < 85);
            md = ($urandom_range(0, 99) < 10);
            ld = !md && ($urandom_range(0, 99) < 30);
            fl = ($urandom_range(0, 99) < 10);
            hd = ($urandom_range(0, 99) < 10);
            r1 = pool[$urandom_range(0, 5)];
            r2 = pool[$urandom_range(0, 5)];
            w  = md ? 6'd33 : pool[$urandom_range(0, 4)];
            step(v, r1, r2, w, ld, md, fl, hd, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
